// File: rtl/mux_pipe_bank.sv
// Bank of independent 2:1 muxes feeding a DEPTH-stage registered delay line, with
// LOAD/HOLD/SHIFT/CLEAR modes, a pipeline-filled flag and a saturating q-change counter.
module mux_pipe_bank #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [WIDTH-1:0]          ser_in,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] q_n,
  output logic                      valid,
  output logic [CNT_W-1:0]          chg_cnt
);

  localparam int BUS_W  = CHANNELS * WIDTH;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_e;

  // Stage s holds all channels packed exactly like a/b/q.
  logic [DEPTH-1:0][BUS_W-1:0] stg_q, stg_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic                        valid_q, valid_d;
  logic [CNT_W-1:0]            chg_cnt_q, chg_cnt_d;

  mode_e mode_s;
  logic  clear;
  logic  advance;

  assign mode_s  = mode_e'(mode);
  assign clear   = en && (mode_s == MODE_CLEAR);
  assign advance = en && ((mode_s == MODE_LOAD) || (mode_s == MODE_SHIFT));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    stg_d     = stg_q;
    fill_d    = fill_q;
    valid_d   = valid_q;
    chg_cnt_d = chg_cnt_q;

    if (clear) begin
      stg_d     = '0;
      fill_d    = '0;
      valid_d   = 1'b0;
      chg_cnt_d = '0;
    end else if (advance) begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        stg_d[s] = stg_q[s-1];
      end

      if (mode_s == MODE_LOAD) begin
        for (int i = 0; i < CHANNELS; i++) begin
          stg_d[0][i*WIDTH +: WIDTH] = sel[i] ? a[i*WIDTH +: WIDTH] : b[i*WIDTH +: WIDTH];
        end
      end else begin
        // Serial path moves toward higher channel index; the top channel falls off.
        for (int i = CHANNELS - 1; i >= 1; i--) begin
          stg_d[0][i*WIDTH +: WIDTH] = stg_q[0][(i-1)*WIDTH +: WIDTH];
        end
        stg_d[0][WIDTH-1:0] = ser_in;
      end

      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
      valid_d = (fill_d == FILL_FULL);

      if ((stg_d[DEPTH-1] != stg_q[DEPTH-1]) && (chg_cnt_q != CNT_MAX)) begin
        chg_cnt_d = chg_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q     <= '0;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      stg_q     <= stg_d;
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign q       = stg_q[DEPTH-1];
  assign q_n     = ~stg_q[DEPTH-1];
  assign valid   = valid_q;
  assign chg_cnt = chg_cnt_q;

endmodule
